// File: rtl/alu32_op_issuer_if.sv
// Request/response bundle between an operation source and alu32_op_issuer.
// The request channel carries operands and opcode; the response channel returns
// the captured ALU flags and result.
interface alu32_op_issuer_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_err;

    // Source side: issues requests, consumes responses.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );

    // Issuer side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/alu32_op_issuer.sv
// Sequential initiator for an external ALU32: registers one request onto the ALU
// inputs, waits SETTLE cycles, captures result/flags into a response register and
// keeps saturating counts of completed operations and overflowing responses.
module alu32_op_issuer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 1,   // 1..15
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu32_op_issuer_if.slave  bus_if,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_overflow_i,
    output logic [CNT_W-1:0]  op_count_o,
    output logic [CNT_W-1:0]  ovf_count_o,
    output logic              busy_o
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [3:0] SettleM1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic               op_legal;
    logic               ovf_cap;

    // 100, 110 and 111 have no ALU function behind them.
    assign op_legal = (bus_if.req_op != 3'b100) && (bus_if.req_op[2:1] != 2'b11);

    // Next-state and datapath load decisions.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        op_cnt_d    = op_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_cap     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_if.req_valid) begin
                    if (op_legal) begin
                        a_d     = bus_if.req_a;
                        b_d     = bus_if.req_b;
                        ctrl_d  = bus_if.req_op;
                        wait_d  = SettleM1;
                        state_d = StWait;
                    end else begin
                        // Illegal op answers immediately; ALU inputs stay put.
                        err_d       = 1'b1;
                        res_d       = '0;
                        zero_d      = 1'b0;
                        ovf_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            StWait: begin
                if (wait_q == 4'd0) begin
                    // Overflow only has meaning for signed add/subtract.
                    ovf_cap     = alu_overflow_i && (ctrl_q == OpAdd || ctrl_q == OpSub);
                    res_d       = alu_result_i;
                    zero_d      = alu_zero_i;
                    ovf_d       = ovf_cap;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                    if (op_cnt_q != '1) begin
                        op_cnt_d = op_cnt_q + 1'b1;
                    end
                    if (ovf_cap && (ovf_cnt_q != '1)) begin
                        ovf_cnt_d = ovf_cnt_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: begin
                if (bus_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset that discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            op_cnt_q    <= op_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign bus_if.req_ready    = (state_q == StIdle) && !rst;
    assign bus_if.rsp_valid    = rsp_valid_q;
    assign bus_if.rsp_result   = res_q;
    assign bus_if.rsp_zero     = zero_q;
    assign bus_if.rsp_overflow = ovf_q;
    assign bus_if.rsp_err      = err_q;

    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_ctrl_o  = ctrl_q;
    assign op_count_o  = op_cnt_q;
    assign ovf_count_o = ovf_cnt_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu32_op_issuer.sv
// Directed bench for alu32_op_issuer. Two instances: SETTLE=1/CNT_W=16 for the
// functional steps, SETTLE=3/CNT_W=2 for reset-abort, longer latency and
// counter saturation. A behavioural ALU32 sits behind each instance.
module tb_alu32_op_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;        // 0 selects instance 0, 1 selects instance 1
    logic        force_ovf;  // makes the ALU model raise Overflow for any op
    logic        req_valid_v;
    logic [31:0] req_a_v, req_b_v;
    logic [2:0]  req_op_v;
    logic        rsp_ready_v;

    alu32_op_issuer_if #(.WIDTH(32)) if0 ();
    alu32_op_issuer_if #(.WIDTH(32)) if1 ();

    assign if0.req_valid = req_valid_v & ~sel;
    assign if1.req_valid = req_valid_v & sel;
    assign if0.req_a     = req_a_v;
    assign if1.req_a     = req_a_v;
    assign if0.req_b     = req_b_v;
    assign if1.req_b     = req_b_v;
    assign if0.req_op    = req_op_v;
    assign if1.req_op    = req_op_v;
    assign if0.rsp_ready = rsp_ready_v & ~sel;
    assign if1.rsp_ready = rsp_ready_v & sel;

    logic [31:0] alu_a0, alu_b0, alu_res0, alu_a1, alu_b1, alu_res1;
    logic [2:0]  alu_ctrl0, alu_ctrl1;
    logic        alu_zero0, alu_ovf0, alu_zero1, alu_ovf1;
    logic [15:0] opc0, ovfc0;
    logic [1:0]  opc1, ovfc1;
    logic        busy0, busy1;

    // Behavioural ALU32: returns {overflow, zero, result}.
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic fo);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            3'b000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b001: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = {31'd0, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return {v | fo, (r == 32'd0), r};
    endfunction

    assign {alu_ovf0, alu_zero0, alu_res0} = alu_f(alu_a0, alu_b0, alu_ctrl0, force_ovf);
    assign {alu_ovf1, alu_zero1, alu_res1} = alu_f(alu_a1, alu_b1, alu_ctrl1, force_ovf);

    alu32_op_issuer #(.WIDTH(32), .SETTLE(1), .CNT_W(16)) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .bus_if         (if0),
        .alu_a_o        (alu_a0),
        .alu_b_o        (alu_b0),
        .alu_ctrl_o     (alu_ctrl0),
        .alu_result_i   (alu_res0),
        .alu_zero_i     (alu_zero0),
        .alu_overflow_i (alu_ovf0),
        .op_count_o     (opc0),
        .ovf_count_o    (ovfc0),
        .busy_o         (busy0)
    );

    alu32_op_issuer #(.WIDTH(32), .SETTLE(3), .CNT_W(2)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .bus_if         (if1),
        .alu_a_o        (alu_a1),
        .alu_b_o        (alu_b1),
        .alu_ctrl_o     (alu_ctrl1),
        .alu_result_i   (alu_res1),
        .alu_zero_i     (alu_zero1),
        .alu_overflow_i (alu_ovf1),
        .op_count_o     (opc1),
        .ovf_count_o    (ovfc1),
        .busy_o         (busy1)
    );

    // Observed view of the selected instance.
    logic        m_req_ready, m_rsp_valid, m_zero, m_ovf, m_err, m_busy;
    logic [31:0] m_result, m_alu_a, m_alu_b;
    logic [2:0]  m_ctrl;
    logic [15:0] m_opc, m_ovfc;

    always_comb begin
        if (sel) begin
            m_req_ready = if1.req_ready;  m_rsp_valid = if1.rsp_valid;
            m_result    = if1.rsp_result; m_zero      = if1.rsp_zero;
            m_ovf       = if1.rsp_overflow; m_err     = if1.rsp_err;
            m_alu_a     = alu_a1;  m_alu_b = alu_b1;  m_ctrl = alu_ctrl1;
            m_opc       = {14'd0, opc1};  m_ovfc = {14'd0, ovfc1};  m_busy = busy1;
        end else begin
            m_req_ready = if0.req_ready;  m_rsp_valid = if0.rsp_valid;
            m_result    = if0.rsp_result; m_zero      = if0.rsp_zero;
            m_ovf       = if0.rsp_overflow; m_err     = if0.rsp_err;
            m_alu_a     = alu_a0;  m_alu_b = alu_b0;  m_ctrl = alu_ctrl0;
            m_opc       = opc0;  m_ovfc = ovfc0;  m_busy = busy0;
        end
    end

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_opc[2];
    int   exp_ovfc[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        check({tag, " alu_a"},     m_alu_a, 32'd0);
        check({tag, " alu_b"},     m_alu_b, 32'd0);
        check({tag, " alu_ctrl"},  32'(m_ctrl), 32'd0);
        check({tag, " rsp_flags"}, {29'd0, m_zero, m_ovf, m_err}, 32'd0);
        check({tag, " rsp_result"}, m_result, 32'd0);
        check({tag, " op_count"},  32'(m_opc), 32'd0);
        check({tag, " ovf_count"}, 32'(m_ovfc), 32'd0);
        check({tag, " busy"},      32'(m_busy), 32'd0);
    endtask

    // Issue one request on the selected instance, wait for its response, hold it
    // for 'hold' cycles with rsp_ready low, then consume it.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] er, input logic ez,
                         input logic eo, input logic ee, input int hold);
        exp_t        e;
        exp_t        g;
        logic        legal;
        logic [2:0]  ctrl_before;
        int          lat;
        int          cap;
        int          s;
        s     = sel ? 1 : 0;
        cap   = sel ? 3 : 65535;
        legal = (op != 3'b100) && (op[2:1] != 2'b11);
        e.res = er; e.zero = ez; e.ovf = eo; e.err = ee;
        // Edges after the accept edge: SETTLE for legal ops, illegal ops respond
        // at the accept edge itself.
        e.lat = legal ? (sel ? 3 : 1) : 0;
        sb.push_back(e);
        ctrl_before = m_ctrl;

        check({tag, " req_ready_idle"}, 32'(m_req_ready), 32'd1);
        req_a_v = a; req_b_v = b; req_op_v = op; req_valid_v = 1'b1;
        @(posedge clk); #1;
        req_valid_v = 1'b0;
        check({tag, " alu_ctrl"}, 32'(m_ctrl), 32'(legal ? op : ctrl_before));
        check({tag, " busy"}, 32'(m_busy), 32'd1);
        check({tag, " req_ready_busy"}, 32'(m_req_ready), 32'd0);

        lat = 0;
        while (!m_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " rsp_valid"}, 32'(m_rsp_valid), 32'd1);
        g = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(g.lat));
        check({tag, " result"}, m_result, g.res);
        check({tag, " flags"}, {29'd0, m_zero, m_ovf, m_err}, {29'd0, g.zero, g.ovf, g.err});

        if (legal) begin
            if (exp_opc[s] < cap) exp_opc[s]++;
            if (eo && exp_ovfc[s] < cap) exp_ovfc[s]++;
        end
        check({tag, " op_count"},  32'(m_opc), 32'(exp_opc[s]));
        check({tag, " ovf_count"}, 32'(m_ovfc), 32'(exp_ovfc[s]));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 32'(m_rsp_valid), 32'd1);
            check({tag, " hold_result"}, m_result, g.res);
            check({tag, " hold_flags"}, {29'd0, m_zero, m_ovf, m_err},
                  {29'd0, g.zero, g.ovf, g.err});
            check({tag, " hold_req_ready"}, 32'(m_req_ready), 32'd0);
            check({tag, " hold_busy"}, 32'(m_busy), 32'd1);
        end

        rsp_ready_v = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v = 1'b0;
        check({tag, " released"}, 32'(m_rsp_valid), 32'd0);
        check({tag, " idle_busy"}, 32'(m_busy), 32'd0);
        check({tag, " idle_req_ready"}, 32'(m_req_ready), 32'd1);
        check({tag, " result_kept"}, m_result, g.res);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; force_ovf = 1'b0;
        req_valid_v = 1'b0; req_a_v = '0; req_b_v = '0; req_op_v = '0; rsp_ready_v = 1'b0;
        exp_opc = '{0, 0}; exp_ovfc = '{0, 0};

        // Reset state of both instances, req_ready held low while rst=1.
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst0");
        check("rst0 req_ready", 32'(m_req_ready), 32'd0);
        sel = 1'b1; #1;
        check_reset_state("rst1");
        check("rst1 req_ready", 32'(m_req_ready), 32'd0);
        sel = 1'b0;
        rst = 1'b0; #1;
        check("rst_release req_ready", 32'(m_req_ready), 32'd1);

        // Basic ADD and SUB.
        do_op("add",     32'h0000_1234, 32'h0000_4321, 3'b000, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 0);
        do_op("sub_zero", 32'h0000_8000, 32'h0000_8000, 3'b001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
        do_op("sub",     32'h0000_F000, 32'h0000_1234, 3'b001, 32'h0000_DDCC, 1'b0, 1'b0, 1'b0, 0);

        // Signed overflow, and masking of Overflow for logic ops.
        do_op("add_ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        do_op("add_ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        force_ovf = 1'b1;
        do_op("and_mask", 32'h0000_AAAA, 32'h0000_CCCC, 3'b010, 32'h0000_8888, 1'b0, 1'b0, 1'b0, 0);
        do_op("or_mask",  32'h0000_F000, 32'h0000_000F, 3'b011, 32'h0000_F00F, 1'b0, 1'b0, 1'b0, 0);
        force_ovf = 1'b0;

        // SLT both directions; second response held off for 3 cycles.
        do_op("slt_lt", 32'hFFFF_FFCE, 32'h0000_0005, 3'b101, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
        do_op("slt_ge", 32'h0000_0005, 32'hFFFF_FFCE, 3'b101, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3);

        // Illegal opcodes: error response, ALU control and op_count untouched.
        do_op("illegal110", 32'h0000_1130, 32'h0000_0000, 3'b110, 32'h0, 1'b0, 1'b0, 1'b1, 0);
        do_op("illegal100", 32'h0000_0001, 32'h0000_0001, 3'b100, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        do_op("add_after_err", 32'h0000_0001, 32'h0000_0002, 3'b000, 32'h3, 1'b0, 1'b0, 1'b0, 0);

        // SETTLE=3 instance: reset one cycle after an accept aborts the op.
        sel = 1'b1; #1;
        do_op("s3_add", 32'h0000_0010, 32'h0000_0020, 3'b000, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 0);
        req_a_v = 32'h0000_0100; req_b_v = 32'h0000_0200; req_op_v = 3'b000; req_valid_v = 1'b1;
        @(posedge clk); #1;
        req_valid_v = 1'b0;
        rst = 1'b1; #1;
        check("abort req_ready_in_rst", 32'(m_req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_opc = '{0, 0}; exp_ovfc = '{0, 0};
        check_reset_state("abort");
        #1;
        check("abort req_ready", 32'(m_req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort no_rsp", 32'(m_rsp_valid), 32'd0);
        end
        do_op("s3_after_rst", 32'h0000_0007, 32'h0000_0008, 3'b000, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 0);

        // Saturation of both 2-bit counters: they must stick at 3.
        for (int i = 0; i < 4; i++) begin
            do_op("s3_sat", 32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000,
                  1'b0, 1'b1, 1'b0, 0);
        end
        check("sat op_count",  32'(m_opc), 32'd3);
        check("sat ovf_count", 32'(m_ovfc), 32'd3);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
